// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch/strobe debounce stage.
// States encode the debounced level plus whether a transition is being qualified.
package debounce_pkg;

  localparam int STATE_W           = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_t;

  // Debounced output level implied by a state.
  function automatic logic state_level(input state_t s);
    return (s == IDLE_HI) || (s == CHK_LO);
  endfunction

  // High while a candidate transition is being qualified.
  function automatic logic state_checking(input state_t s);
    return (s == CHK_HI) || (s == CHK_LO);
  endfunction

endpackage

// File: rtl/debounce_sync_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Reused by other async-input stages; synchronous reset clears both flops.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
    end
  end

  assign q = s2_reg;

endmodule

// File: rtl/debounce_sync.sv
// Debounces one asynchronous input: sync_2ff, then a 4-state qualifier FSM.
// Build with DEBOUNCE_EDGE_PULSE_EN defined to get the rise/fall pulse registers.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic busy,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s2;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dout_reg, dout_next;
  logic             busy_reg, busy_next;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (s2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE_LO;
      cnt_reg   <= '0;
      dout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE_LO: begin
        if (s2) begin
          state_next = CHK_HI;
          cnt_next   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_next = IDLE_LO;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s2) begin
          state_next = CHK_LO;
          cnt_next   = CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_next = IDLE_HI;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LO;
        cnt_next   = '0;
      end
    endcase
    // Level and busy are registered alongside the state so they change together.
    dout_next = state_level(state_next);
    busy_next = state_checking(state_next);
  end

  assign dout = dout_reg;
  assign busy = busy_reg;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_reg, rise_next;
  logic fall_reg, fall_next;

  // A pulse fires only when a qualification completes, never on a glitch abort.
  assign rise_next = (state_reg == CHK_HI) && (state_next == IDLE_HI);
  assign fall_next = (state_reg == CHK_LO) && (state_next == IDLE_LO);

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
